// File: rtl/mem_access_unit.sv
// Load/store initiator for a 16-bit word-addressed data memory: one request at a time,
// byte stores by read-modify-write, byte loads sign/zero-extended.
module mem_access_unit #(
  parameter int MEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_mode,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd,
  output logic        mem_wn,
  output logic [15:0] mem_address,
  output logic [1:0]  mem_mode,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_MRG, RMW_WR, RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  localparam logic [16:0] WORD_LIMIT = 17'(MEM_WORDS);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        rv_q, rv_d;

  logic        accept, req_err, byte_hi;
  logic [7:0]  rd_byte;
  logic [15:0] ld_val, merged;

  assign accept  = req_valid && (state_q == IDLE);
  assign req_err = (req_mode == 2'b11)
                || ((req_mode == 2'b00) && req_addr[0])
                || ({2'b00, req_addr[15:1]} >= WORD_LIMIT);

  // Byte lane is chosen by the latched address LSB, both for loads and the RMW merge.
  assign byte_hi = req_q.addr[0];
  assign rd_byte = byte_hi ? mem_read_data[15:8] : mem_read_data[7:0];
  assign merged  = byte_hi ? {req_q.wdata[7:0], mem_read_data[7:0]}
                           : {mem_read_data[15:8], req_q.wdata[7:0]};

  always_comb begin
    case (req_q.mode)
      2'b00:   ld_val = mem_read_data;
      2'b01:   ld_val = {8'h00, rd_byte};
      default: ld_val = {{8{rd_byte[7]}}, rd_byte};
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (req_err)                  state_d = RESP;
        else if (!req_we)             state_d = LD_RD;
        else if (req_mode == 2'b00)   state_d = ST_WR;
        else                          state_d = RMW_RD;
      end
      LD_RD:   state_d = LD_CAP;
      LD_CAP:  state_d = RESP;
      ST_WR:   state_d = RESP;
      RMW_RD:  state_d = RMW_MRG;
      RMW_MRG: state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      RESP:    if (rv_q && resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    mem_wn    = 1'b0;
    case (state_q)
      IDLE:           req_ready = 1'b1;
      LD_RD, RMW_RD:  mem_rd    = 1'b1;
      ST_WR, RMW_WR:  mem_wn    = 1'b1;
      default: ;
    endcase
  end

  // Request latch, load capture and response flags
  always_comb begin
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      req_d   = '{we: req_we, mode: req_mode, addr: req_addr, wdata: req_wdata};
      rdata_d = '0;
      err_d   = req_err;
    end
    if (state_q == LD_CAP)  rdata_d     = ld_val;
    if (state_q == RMW_MRG) req_d.wdata = merged;
    // Valid rises one cycle after entering RESP and drops right after the handshake.
    rv_d = (state_q == RESP) && !(rv_q && resp_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
    end
  end

  assign resp_valid     = rv_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_address    = {1'b0, req_q.addr[15:1]};
  assign mem_mode       = req_q.mode;
  assign mem_write_data = req_q.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic scored
// against an arithmetic reference of the load/store rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [1:0]  req_mode = 2'b00;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [15:0] resp_rdata;
  logic        mem_rd, mem_wn;
  logic [15:0] mem_address, mem_write_data;
  logic [1:0]  mem_mode;
  logic [15:0] mem_read_data = '0;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.MEM_WORDS(2048)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_address(mem_address),
    .mem_mode(mem_mode), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: read data valid the cycle after mem_rd.
  logic [15:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_rd) mem_read_data <= mem[mem_address[10:0]];
    if (mem_wn) mem[mem_address[10:0]] <= mem_write_data;
  end

  // Strobe monitor
  int          rd_total = 0, wn_total = 0;
  logic        both_seen = 1'b0;
  logic [15:0] last_rd_addr = '0, last_wn_addr = '0, last_wn_data = '0;
  always @(negedge clk) begin
    if (mem_rd) begin rd_total++; last_rd_addr = mem_address; end
    if (mem_wn) begin wn_total++; last_wn_addr = mem_address; last_wn_data = mem_write_data; end
    if (mem_rd && mem_wn) both_seen = 1'b1;
  end

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwn;
    logic [15:0] rd_addr;
    logic [15:0] wn_addr;
    logic [15:0] wn_data;
    logic        stable;
    logic        cleared;
  } obs_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwn;
    logic [15:0] wn_data;
  } exp_t;

  // Reference: word-indexed memory image updated by the load/store rules.
  logic [15:0] ref_mem [int];

  task automatic model(input logic we, input logic [1:0] mode, input logic [15:0] addr,
                       input logic [15:0] wdata, output exp_t e);
    int idx, w, b, nw;
    idx = int'(addr) / 2;
    e = '{rdata: 16'h0, err: 1'b0, lat: 0, nrd: 0, nwn: 0, wn_data: 16'h0};
    if (mode == 2'd3 || (mode == 2'd0 && addr[0]) || idx >= 2048) begin
      e.err = 1'b1; e.lat = 2;
    end else if (!we) begin
      w = int'(ref_mem[idx]);
      b = addr[0] ? (w / 256) : (w % 256);
      if (mode == 2'd0)      e.rdata = 16'(w);
      else if (mode == 2'd1) e.rdata = 16'(b);
      else                   e.rdata = (b >= 128) ? 16'(b + 65280) : 16'(b);
      e.lat = 4; e.nrd = 1;
    end else if (mode == 2'd0) begin
      ref_mem[idx] = wdata;
      e.lat = 3; e.nwn = 1; e.wn_data = wdata;
    end else begin
      w  = int'(ref_mem[idx]);
      b  = int'(wdata) % 256;
      nw = addr[0] ? (b * 256 + w % 256) : ((w / 256) * 256 + b);
      ref_mem[idx] = 16'(nw);
      e.lat = 5; e.nrd = 1; e.nwn = 1; e.wn_data = 16'(nw);
    end
  endtask

  // Drives one request, measures latency from the accept edge, optionally holds off
  // resp_ready, then completes the handshake.
  task automatic run_req(input logic we, input logic [1:0] mode, input logic [15:0] addr,
                         input logic [15:0] wdata, input int hold, output obs_t o);
    int rd0, wn0;
    @(negedge clk);
    rd0 = rd_total; wn0 = wn_total;
    req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o.lat = 0;
    for (int n = 1; n <= 20 && o.lat == 0; n++) begin
      if (resp_valid) o.lat = n;
      else begin @(posedge clk); #1; end
    end
    o.rdata = resp_rdata; o.err = resp_err; o.stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_rdata !== o.rdata || resp_err !== o.err || req_ready) o.stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    o.cleared = !resp_valid && req_ready;
    o.nrd = rd_total - rd0; o.nwn = wn_total - wn0;
    o.rd_addr = last_rd_addr; o.wn_addr = last_wn_addr; o.wn_data = last_wn_data;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 16'h0) begin
      fails++; $display("FAIL reset_resp: got v=%b e=%b d=%h want 0 0 0000", resp_valid, resp_err, resp_rdata); end
    tests++; if (mem_rd !== 1'b0 || mem_wn !== 1'b0) begin
      fails++; $display("FAIL reset_strobes: got rd=%b wn=%b want 0 0", mem_rd, mem_wn); end
    tests++; if (mem_address !== 16'h0 || mem_mode !== 2'b00 || mem_write_data !== 16'h0) begin
      fails++; $display("FAIL reset_mem_bus: got a=%h m=%b d=%h want 0", mem_address, mem_mode, mem_write_data); end
  endtask

  task automatic test_word_store_load;
    obs_t o; exp_t e;
    model(1'b1, 2'b00, 16'h0010, 16'hBEEF, e);
    run_req(1'b1, 2'b00, 16'h0010, 16'hBEEF, 0, o);
    tests++; if (o.nwn !== 1 || o.nrd !== 0) begin fails++; $display("FAIL wstore_strobes: got rd=%0d wn=%0d want 0 1", o.nrd, o.nwn); end
    tests++; if (o.wn_addr !== 16'h0008 || o.wn_data !== 16'hBEEF) begin
      fails++; $display("FAIL wstore_bus: got a=%h d=%h want 0008 beef", o.wn_addr, o.wn_data); end
    tests++; if (o.lat !== 3 || o.err !== 1'b0) begin fails++; $display("FAIL wstore_lat: got lat=%0d err=%b want 3 0", o.lat, o.err); end
    model(1'b0, 2'b00, 16'h0010, 16'h0, e);
    run_req(1'b0, 2'b00, 16'h0010, 16'h0, 0, o);
    tests++; if (o.rdata !== 16'hBEEF || o.err !== 1'b0) begin
      fails++; $display("FAIL wload_data: got %h err=%b want beef 0", o.rdata, o.err); end
    tests++; if (o.lat !== 4 || o.nrd !== 1 || o.nwn !== 0 || o.rd_addr !== 16'h0008) begin
      fails++; $display("FAIL wload_timing: got lat=%0d rd=%0d wn=%0d a=%h want 4 1 0 0008", o.lat, o.nrd, o.nwn, o.rd_addr); end
  endtask

  task automatic test_byte_loads;
    obs_t o; exp_t e;
    logic [15:0] addrs [3];
    logic [1:0]  modes [3];
    logic [15:0] want  [3];
    addrs = '{16'h0011, 16'h0011, 16'h0010};
    modes = '{2'b10, 2'b01, 2'b10};
    want  = '{16'hFF80, 16'h0080, 16'hFFF3};
    model(1'b1, 2'b00, 16'h0010, 16'h80F3, e);
    run_req(1'b1, 2'b00, 16'h0010, 16'h80F3, 0, o);
    for (int i = 0; i < 3; i++) begin
      model(1'b0, modes[i], addrs[i], 16'h0, e);
      run_req(1'b0, modes[i], addrs[i], 16'h0, 0, o);
      tests++; if (o.rdata !== want[i] || o.lat !== 4) begin
        fails++; $display("FAIL byte_load_%0d: got %h lat=%0d want %h lat=4", i, o.rdata, o.lat, want[i]); end
    end
  endtask

  task automatic test_byte_store;
    obs_t o; exp_t e;
    model(1'b1, 2'b01, 16'h0011, 16'h0042, e);
    run_req(1'b1, 2'b01, 16'h0011, 16'h0042, 0, o);
    tests++; if (o.nrd !== 1 || o.nwn !== 1 || o.wn_data !== 16'h42F3 || o.wn_addr !== 16'h0008) begin
      fails++; $display("FAIL byte_store_bus: got rd=%0d wn=%0d d=%h a=%h want 1 1 42f3 0008", o.nrd, o.nwn, o.wn_data, o.wn_addr); end
    tests++; if (o.lat !== 5 || o.err !== 1'b0 || o.rdata !== 16'h0) begin
      fails++; $display("FAIL byte_store_resp: got lat=%0d err=%b d=%h want 5 0 0000", o.lat, o.err, o.rdata); end
    model(1'b0, 2'b00, 16'h0010, 16'h0, e);
    run_req(1'b0, 2'b00, 16'h0010, 16'h0, 0, o);
    tests++; if (o.rdata !== 16'h42F3) begin fails++; $display("FAIL byte_store_readback: got %h want 42f3", o.rdata); end
  endtask

  task automatic test_errors;
    obs_t o;
    logic [15:0] addrs [3];
    logic [1:0]  modes [3];
    addrs = '{16'h0011, 16'h0010, 16'h1000};
    modes = '{2'b00, 2'b11, 2'b01};
    for (int i = 0; i < 3; i++) begin
      run_req(1'b0, modes[i], addrs[i], 16'h1234, 0, o);
      tests++; if (o.err !== 1'b1 || o.rdata !== 16'h0 || o.lat !== 2 || o.nrd !== 0 || o.nwn !== 0) begin
        fails++; $display("FAIL error_%0d: got err=%b d=%h lat=%0d rd=%0d wn=%0d want 1 0000 2 0 0",
                          i, o.err, o.rdata, o.lat, o.nrd, o.nwn); end
    end
    run_req(1'b1, 2'b01, 16'hFFFF, 16'h00AA, 0, o);
    tests++; if (o.err !== 1'b1 || o.nrd !== 0 || o.nwn !== 0) begin
      fails++; $display("FAIL error_store_range: got err=%b rd=%0d wn=%0d want 1 0 0", o.err, o.nrd, o.nwn); end
  endtask

  task automatic test_backpressure;
    obs_t o; exp_t e;
    model(1'b0, 2'b01, 16'h0010, 16'h0, e);
    run_req(1'b0, 2'b01, 16'h0010, 16'h0, 5, o);
    tests++; if (o.stable !== 1'b1 || o.rdata !== 16'h00F3) begin
      fails++; $display("FAIL hold_stable: got stable=%b d=%h want 1 00f3", o.stable, o.rdata); end
    tests++; if (o.cleared !== 1'b1) begin fails++; $display("FAIL hold_release: got cleared=%b want 1", o.cleared); end
    // Next request goes in the cycle right after the handshake.
    model(1'b0, 2'b10, 16'h0011, 16'h0, e);
    run_req(1'b0, 2'b10, 16'h0011, 16'h0, 0, o);
    tests++; if (o.rdata !== 16'h0042 || o.lat !== 4) begin
      fails++; $display("FAIL back_to_back: got %h lat=%0d want 0042 lat=4", o.rdata, o.lat); end
  endtask

  task automatic test_reset_mid_rmw;
    obs_t o; exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_mode = 2'b01; req_addr = 16'h0011; req_wdata = 16'h0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL rmw_rd_before_reset: got %b want 1", mem_rd); end
    rst_n = 1'b0; #1;
    tests++; if (mem_rd !== 1'b0 || mem_wn !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL reset_mid_rmw: got rd=%b wn=%b rdy=%b v=%b want 0 0 1 0", mem_rd, mem_wn, req_ready, resp_valid); end
    @(negedge clk); rst_n = 1'b1;
    model(1'b0, 2'b00, 16'h0010, 16'h0, e);
    run_req(1'b0, 2'b00, 16'h0010, 16'h0, 0, o);
    tests++; if (o.rdata !== 16'h42F3 || o.lat !== 4 || o.err !== 1'b0) begin
      fails++; $display("FAIL load_after_reset: got %h lat=%0d err=%b want 42f3 4 0", o.rdata, o.lat, o.err); end
  endtask

  task automatic test_random;
    obs_t o; exp_t e;
    int pool [8];
    int idx, hold;
    logic we; logic [1:0] mode; logic [15:0] addr, wdata;
    pool = '{0, 1, 2, 3, 8, 100, 2046, 2047};
    for (int i = 0; i < 8; i++) begin
      wdata = 16'($urandom);
      model(1'b1, 2'b00, 16'(pool[i] * 2), wdata, e);
      run_req(1'b1, 2'b00, 16'(pool[i] * 2), wdata, 0, o);
      tests++; if (o.wn_data !== e.wn_data || o.nwn !== 1) begin
        fails++; $display("FAIL rnd_init_%0d: got %h wn=%0d want %h 1", i, o.wn_data, o.nwn, e.wn_data); end
    end
    for (int t = 0; t < 80; t++) begin
      idx   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2048, 32767)) : pool[$urandom_range(0, 7)];
      addr  = 16'(idx * 2 + int'($urandom_range(0, 1)));
      we    = 1'($urandom_range(0, 1));
      mode  = 2'($urandom_range(0, 3));
      wdata = 16'($urandom);
      hold  = int'($urandom_range(0, 2));
      model(we, mode, addr, wdata, e);
      run_req(we, mode, addr, wdata, hold, o);
      tests++; if (o.rdata !== e.rdata || o.err !== e.err) begin
        fails++; $display("FAIL rnd_%0d_resp: we=%b m=%0d a=%h got d=%h e=%b want d=%h e=%b", t, we, mode, addr, o.rdata, o.err, e.rdata, e.err); end
      tests++; if (o.lat !== e.lat || o.nrd !== e.nrd || o.nwn !== e.nwn) begin
        fails++; $display("FAIL rnd_%0d_timing: got lat=%0d rd=%0d wn=%0d want %0d %0d %0d", t, o.lat, o.nrd, o.nwn, e.lat, e.nrd, e.nwn); end
      if (e.nwn == 1) begin
        tests++; if (o.wn_data !== e.wn_data || o.wn_addr !== 16'(idx)) begin
          fails++; $display("FAIL rnd_%0d_write: got d=%h a=%h want %h %h", t, o.wn_data, o.wn_addr, e.wn_data, 16'(idx)); end
      end
      tests++; if (o.stable !== 1'b1 || o.cleared !== 1'b1) begin
        fails++; $display("FAIL rnd_%0d_handshake: got stable=%b cleared=%b want 1 1", t, o.stable, o.cleared); end
    end
    tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL strobe_overlap: got %b want 0", both_seen); end
  endtask

  initial begin
    test_reset;
    test_word_store_load;
    test_byte_loads;
    test_byte_store;
    test_errors;
    test_backpressure;
    test_reset_mid_rmw;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: the CPU's load/store unit that drives rd/wn/address/mode/write_data and consumes read_data from the 16-bit word-addressed data memory.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Converts byte addresses to word addresses, performs byte stores by read-modify-write, sign/zero-extends byte loads, and returns a response over a second valid/ready handshake.

Parameters:
- MEM_WORDS, 2048, number of 16-bit words in data memory; any word index >= MEM_WORDS is out of range.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_mode  input  2  00 word, 01 byte unsigned, 10 byte signed, 11 reserved
- req_addr  input  16  byte address
- req_wdata  input  16  store data; byte stores use bits [7:0]
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  16  load result; 0 for stores and errors
- resp_err  output  1  request rejected, no memory access made
- mem_rd  output  1  memory read strobe
- mem_wn  output  1  memory write strobe
- mem_address  output  16  word index = {1'b0, req_addr[15:1]}
- mem_mode  output  2  latched req_mode, forwarded
- mem_write_data  output  16  word to write
- mem_read_data  input  16  memory read port; valid the cycle after mem_rd was high

Behaviour:
- Reset: state IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0. mem_rd=0, mem_wn=0, mem_address=0, mem_mode=0, mem_write_data=0.
- Reset mid-operation clears the strobes immediately and drops any pending response.
- All outputs are driven from registered state and latched request fields (Moore).
- mem_rd and mem_wn are never high together. Each is high for exactly one cycle per access.
- IDLE: req_ready=1. On req_valid && req_ready, latch we/mode/addr/wdata, then branch:
  - Error: mode==11, OR word mode with addr[0]==1, OR word index >= MEM_WORDS. Go to RESP with resp_err=1 and no strobe.
  - Load: go to LD_RD.
  - Word store: go to ST_WR.
  - Byte store: go to RMW_RD.
- req_ready=0 in every state except IDLE.
- LD_RD: mem_rd=1 → LD_CAP.
- LD_CAP: strobes 0. Capture mem_read_data and select the byte with addr[0] (0 = [7:0], 1 = [15:8]).
  - mode 00: word unchanged.
  - mode 01: zero-extend the byte.
  - mode 10: sign-extend the byte.
  - → RESP.
- ST_WR: mem_wn=1, mem_write_data=wdata → RESP.
- RMW_RD: mem_rd=1 → RMW_MRG.
- RMW_MRG: capture mem_read_data and replace the byte selected by addr[0] with wdata[7:0] → RMW_WR.
- RMW_WR: mem_wn=1, mem_write_data=merged word → RESP.
- RESP: resp_valid=1; resp_rdata and resp_err stay stable until accepted.
  - On resp_ready, go to IDLE and clear resp_valid the next cycle.
  - resp_ready is ignored when resp_valid=0.
- Latency (accept edge = edge 1; resp_valid high after edge N):
  - error N=2
  - word store N=3
  - load N=4
  - byte store N=5
- Back-to-back: a new request can be accepted in the cycle after the response handshake. No overlap between requests.
- mem_address and mem_mode hold their latched values from accept until the next accept.

Test Plan:
- Reset asserted mid-RMW_RD → mem_rd drops immediately, req_ready=1, resp_valid=0. After release, a fresh load proceeds normally.
- Word store addr=0x0010, wdata=0xBEEF, then word load addr=0x0010 → store: mem_wn pulse with mem_address=0x0008; load: resp_rdata=0xBEEF, resp_err=0, resp_valid after edge 4.
- Memory word 0x0008 = 0x80F3:
  - byte-signed load addr=0x0011 → 0xFF80
  - byte-unsigned load addr=0x0011 → 0x0080
  - byte-signed load addr=0x0010 → 0xFFF3
- Byte store addr=0x0011, wdata=0x0042 over word 0x80F3 → mem_rd pulse, then mem_wn pulse with mem_write_data=0x42F3. A later word load returns 0x42F3.
- Error requests, each expecting resp_err=1, no mem_rd/mem_wn, resp_valid after edge 2:
  - word load addr=0x0011
  - mode=11
  - addr=0x1000 (index 0x0800 == MEM_WORDS)
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stay stable and req_ready=0. Release → resp_valid clears next cycle and IDLE accepts the next request.
